// File: rtl/rx32_wb_pkg.sv
// Shared types for the register-file write-back queue.
// Optional bypass search is enabled by defining RX32_WB_BYPASS_EN.
package rx32_wb_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned AW       = 5;
   localparam int unsigned WB_DEPTH = 4;

   typedef struct packed {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wb_entry_t;

   function automatic logic is_x0(input logic [AW-1:0] rd);
      return (rd == '0);
   endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// In-order storage for pending write-back entries: pointers, occupancy,
// full/empty, plus a per-slot valid vector for the bypass search.
module regfile_wb_fifo
   import rx32_wb_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  wb_entry_t                  wdata_i,
   output wb_entry_t                  head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [DEPTH-1:0]           valid_o,
   output wb_entry_t [DEPTH-1:0]      entries_o,
   output logic [$clog2(DEPTH)-1:0]   rd_ptr_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   wb_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // A slot is live when its distance from the head is below the occupancy.
   always_comb begin
      logic [PW-1:0] off;
      off     = '0;
      valid_o = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off        = PW'(i) - rd_ptr_q;
         valid_o[i] = (CW'(off) < count_q);
      end
   end

   assign head_o    = mem_q[rd_ptr_q];
   assign entries_o = mem_q;
   assign rd_ptr_o  = rd_ptr_q;

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-side front end of the 32x32 register file: in-order result queue
// retiring one entry per granted cycle. Bypass search under RX32_WB_BYPASS_EN.
module regfile_wb_queue
   import rx32_wb_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rd,
   input  logic [XLEN-1:0] in_data,
   input  logic            rf_gnt,
   output logic            rf_we,
   output logic [AW-1:0]   rf_wa,
   output logic [XLEN-1:0] rf_wd,
   input  logic [AW-1:0]   q_ra1,
   input  logic [AW-1:0]   q_ra2,
   output logic            q_hit1,
   output logic            q_hit2,
   output logic [XLEN-1:0] q_data1,
   output logic [XLEN-1:0] q_data2,
   output logic            empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   wb_entry_t             wdata, head;
   wb_entry_t [DEPTH-1:0] entries;
   logic [DEPTH-1:0]      valid;
   logic [PW-1:0]         rd_ptr;
   logic                  full, push;

   // Writes to x0 complete the handshake but are never queued.
   assign in_ready   = !full;
   assign push       = in_valid && in_ready && !is_x0(in_rd);
   assign wdata.rd   = in_rd;
   assign wdata.data = in_data;

   assign rf_we = !empty && rf_gnt;
   assign rf_wa = rf_we ? head.rd   : '0;
   assign rf_wd = rf_we ? head.data : '0;

   regfile_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (push),
      .pop_i     (rf_we),
      .wdata_i   (wdata),
      .head_o    (head),
      .full_o    (full),
      .empty_o   (empty),
      .valid_o   (valid),
      .entries_o (entries),
      .rd_ptr_o  (rd_ptr)
   );

`ifdef RX32_WB_BYPASS_EN
   // Walk oldest to youngest so the youngest match overrides earlier ones.
   always_comb begin
      logic [PW-1:0] idx;
      idx     = '0;
      q_hit1  = 1'b0;
      q_hit2  = 1'b0;
      q_data1 = '0;
      q_data2 = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = rd_ptr + PW'(k);
         if (valid[idx] && !is_x0(q_ra1) && (entries[idx].rd == q_ra1)) begin
            q_hit1  = 1'b1;
            q_data1 = entries[idx].data;
         end
         if (valid[idx] && !is_x0(q_ra2) && (entries[idx].rd == q_ra2)) begin
            q_hit2  = 1'b1;
            q_data2 = entries[idx].data;
         end
      end
   end
`else
   assign q_hit1  = 1'b0;
   assign q_hit2  = 1'b0;
   assign q_data1 = '0;
   assign q_data2 = '0;

   logic unused_bypass;
   assign unused_bypass = ^{q_ra1, q_ra2, valid, entries, rd_ptr};
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_regfile_wb_queue;
   import rx32_wb_pkg::*;

`ifdef RX32_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready;
   logic [AW-1:0]   in_rd;
   logic [XLEN-1:0] in_data;
   logic            rf_gnt, rf_we;
   logic [AW-1:0]   rf_wa;
   logic [XLEN-1:0] rf_wd;
   logic [AW-1:0]   q_ra1, q_ra2;
   logic            q_hit1, q_hit2;
   logic [XLEN-1:0] q_data1, q_data2;
   logic            empty;

   int checks   = 0;
   int failures = 0;
   bit stall    = 1'b0;

   wb_entry_t mdl_q[$];
   wb_entry_t exp_q[$];

   always #5 clk = ~clk;

   regfile_wb_queue #(.DEPTH(WB_DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_rd    (in_rd),
      .in_data  (in_data),
      .rf_gnt   (rf_gnt),
      .rf_we    (rf_we),
      .rf_wa    (rf_wa),
      .rf_wd    (rf_wd),
      .q_ra1    (q_ra1),
      .q_ra2    (q_ra2),
      .q_hit1   (q_hit1),
      .q_hit2   (q_hit2),
      .q_data1  (q_data1),
      .q_data2  (q_data2),
      .empty    (empty)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Youngest pending write to ra, or no hit.
   function automatic logic [XLEN:0] bp_exp(input logic [AW-1:0] ra);
      logic [XLEN:0] r;
      r = '0;
      if (BYPASS && ra != '0) begin
         foreach (mdl_q[i]) begin
            if (mdl_q[i].rd == ra) r = {1'b1, mdl_q[i].data};
         end
      end
      return r;
   endfunction

   // Drive one cycle; the reference model applies the edge's effects.
   task automatic cyc(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d,
                      input logic g);
      bit do_pop, do_push;
      wb_entry_t e;
      in_valid = v;
      in_rd    = rd;
      in_data  = d;
      rf_gnt   = g;
      @(posedge clk);
      stall = 1'b0;
      if (rst_n) begin
         do_pop  = g && (mdl_q.size() > 0);
         do_push = v && (mdl_q.size() < WB_DEPTH) && (rd != '0);
         stall   = v && (mdl_q.size() >= WB_DEPTH);
         if (do_pop) void'(mdl_q.pop_front());
         if (do_push) begin
            e.rd   = rd;
            e.data = d;
            mdl_q.push_back(e);
            exp_q.push_back(e);
         end
      end
      #1;
   endtask

   // Monitor: compares DUT outputs against the model away from the active edge.
   always @(negedge clk) begin
      wb_entry_t     e;
      logic [XLEN:0] b1, b2;
      chk("in_ready", 64'(in_ready), 64'(mdl_q.size() < WB_DEPTH));
      chk("empty", 64'(empty), 64'(mdl_q.size() == 0));
      chk("rf_we", 64'(rf_we), 64'((mdl_q.size() != 0) && rf_gnt));
      if (rf_we) begin
         chk("sb_has_entry", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rf_wa", 64'(rf_wa), 64'(e.rd));
            chk("rf_wd", 64'(rf_wd), 64'(e.data));
         end
      end else begin
         chk("rf_wa_idle", 64'(rf_wa), 64'(0));
         chk("rf_wd_idle", 64'(rf_wd), 64'(0));
      end
      b1 = bp_exp(q_ra1);
      b2 = bp_exp(q_ra2);
      chk("q_hit1", 64'(q_hit1), 64'(b1[XLEN]));
      chk("q_data1", 64'(q_data1), 64'(b1[XLEN-1:0]));
      chk("q_hit2", 64'(q_hit2), 64'(b2[XLEN]));
      chk("q_data2", 64'(q_data2), 64'(b2[XLEN-1:0]));
   end

   initial begin
      logic            rv;
      logic [AW-1:0]   rrd;
      logic [XLEN-1:0] rdat;
      rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0;
      rf_gnt = 1'b0; q_ra1 = '0; q_ra2 = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single push retires one cycle later
      cyc(1'b1, AW'(5), 32'hDEADBEEF, 1'b1);
      cyc(1'b0, '0, '0, 1'b1);
      cyc(1'b0, '0, '0, 1'b1);

      // Fill with grant off, hold fifth offer, then drain in order
      for (int i = 1; i <= 4; i++) cyc(1'b1, AW'(i), 32'(32'hA000 + i), 1'b0);
      cyc(1'b1, AW'(9), 32'h5555, 1'b0);
      cyc(1'b1, AW'(9), 32'h5555, 1'b0);
      cyc(1'b1, AW'(9), 32'h5555, 1'b1);
      cyc(1'b1, AW'(9), 32'h5555, 1'b1);
      repeat (6) cyc(1'b0, '0, '0, 1'b1);

      // x0 write is accepted and dropped
      cyc(1'b1, '0, 32'h1234, 1'b1);
      repeat (2) cyc(1'b0, '0, '0, 1'b1);

      // Two pending writes to rd=7: youngest data visible, x0 query never hits
      q_ra1 = AW'(7); q_ra2 = '0;
      cyc(1'b1, AW'(7), 32'h11, 1'b0);
      cyc(1'b1, AW'(7), 32'h22, 1'b0);
      cyc(1'b0, '0, '0, 1'b0);
      q_ra2 = AW'(7);
      repeat (3) cyc(1'b0, '0, '0, 1'b1);

      // Reset mid-burst with three entries pending
      for (int i = 0; i < 3; i++) cyc(1'b1, AW'(10 + i), 32'(32'hC0 + i), 1'b0);
      rst_n = 1'b0;
      mdl_q.delete();
      exp_q.delete();
      repeat (2) cyc(1'b1, AW'(3), 32'hBAD, 1'b1);
      rst_n = 1'b1;
      cyc(1'b0, '0, '0, 1'b1);

      // Random traffic; a stalled offer is held stable until accepted
      rv = 1'b0; rrd = '0; rdat = '0;
      for (int n = 0; n < 400; n++) begin
         if (!stall) begin
            rv   = ($urandom_range(0, 3) != 0);
            rrd  = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            rdat = $urandom;
         end
         q_ra1 = AW'($urandom_range(0, 7));
         q_ra2 = AW'($urandom_range(0, 7));
         cyc(rv, rrd, rdat, ($urandom_range(0, 2) != 0));
      end

      repeat (WB_DEPTH + 2) cyc(1'b0, '0, '0, 1'b1);
      chk("sb_drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
